mmio_io_ctrl: RTL
=================

# mmio_io_ctrl

Memory-mapped I/O controller on the CPU memory bus, alongside the RAM. Decodes the CPU's `mem_cmd`/`mem_addr` and handles two I/O addresses:
- an LED output register, writable and readable back;
- a debounced switch input port, read-only.

Read data is registered, giving the same one-cycle read latency as the RAM. The top level muxes RAM and I/O read data using `io_rd_drive`; no tri-states.

## Interface
Parameters:
- `LED_ADDR`, 9'h100, address of the LED register.
- `SW_ADDR`, 9'h140, address of the switch port.
- `DEB_CYCLES`, 4, number of consecutive stable synchronized samples required to accept a switch change. Must be ≥1.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `reset_n` in 1: asynchronous reset, active-low.
- `mem_cmd` in 2: bus command (none / read / write).
- `mem_addr` in 9: bus address.
- `write_data` in 16: CPU store data.
- `sw_in` in 8: raw, asynchronous, bouncing switches.
- `led_out` out 8: LED register.
- `io_rd_data` out 16: registered read data.
- `io_rd_drive` out 1: registered; 1 when `io_rd_data` must be routed to the CPU `read_data` input.
- `sw_stable` out 8: debounced switch value.
- `sw_event` out 1: one-cycle pulse when `sw_stable` changes.

## Operation
- Commands: `MNONE` = 2'b00, `MREAD` = 2'b01, `MWRITE` = 2'b10. Command 2'b11 is treated as `MNONE`.
- **LED write:** `mem_cmd == MWRITE` and `mem_addr == LED_ADDR` → `led_out <= write_data[7:0]`. `write_data[15:8]` is discarded.
- **Ignored writes:** writes to `SW_ADDR` and to any other address have no effect.
- **Reads:** `mem_cmd == MREAD` and an address hit → `io_rd_drive <= 1`, with `io_rd_data` set as follows:
  - `LED_ADDR` → `{8'h00, led_out}`, using the value before any write on the same edge. A write and a read cannot both occur in one cycle.
  - `SW_ADDR` → `{8'h00, sw_stable}`.
- **No hit:** any other case (no read, or read of another address) → `io_rd_drive <= 0`, `io_rd_data <= 16'h0000`.
- **Synchronizer:** `sw_in` passes through a 2-flop synchronizer → `s2`. A delayed copy `s2_d` is kept.
- **Debounce**, one shared counter `cnt` of width `$clog2(DEB_CYCLES+1)`:
  - If `s2 != sw_stable` and `s2 == s2_d`:
    - when `cnt == DEB_CYCLES-1`: `sw_stable <= s2`, `cnt <= 0`, `sw_event <= 1`;
    - otherwise `cnt <= cnt+1`.
  - In every other case: `cnt <= 0`, `sw_event <= 0`.
  - Any bounce restarts the count.
  - If a bit returns to its stable value mid-count, the count also restarts, and no event is generated.
- **Reset:** `reset_n` low at any time, including mid-debounce or mid-read, asynchronously clears all of the following to 0: `led_out`, `io_rd_data`, `io_rd_drive`, `sw_stable`, `sw_event`, `cnt`, both synchronizer stages, and `s2_d`.

## Timing
- LED write: `led_out` shows the new value immediately after the edge that samples the write. Latency 1.
- Read: command sampled at edge N; `io_rd_data`/`io_rd_drive` are valid after edge N and held until edge N+1. The CPU samples them in cycle N+1.
- Back-to-back reads on consecutive cycles: each result holds for exactly one cycle.
- `io_rd_drive` never asserts for a RAM address (`mem_addr[8] == 0`).
- Switch latency: a `sw_in` change first captured at edge 1 (and held steady) updates `sw_stable` at edge 3+`DEB_CYCLES`. With the default, that is edge 7.
  - `sw_event` is high for exactly the cycle following that edge.
- Switch changes and bus accesses are independent and may occur in the same cycle.
  - A read of `SW_ADDR` on the edge where `sw_stable` updates returns the old value.

## Structure
- Shared package `mem_bus_pkg`: `MNONE`/`MREAD`/`MWRITE` constants, the `LED_ADDR`/`SW_ADDR` defaults, and the address width (9) and data width (16). The CPU and the top level use the same package.
- Sub-module `sw_debounce`: holds the synchronizer, `s2_d`, the counter, `sw_stable` and `sw_event`, parameterized by `DEB_CYCLES` and width. The address decode and LED/read registers stay in `mmio_io_ctrl`.

## Test plan
- Reset: drive `reset_n` low asynchronously mid-cycle → all outputs 0 immediately. Release, issue no commands → outputs stay 0.
- LED path:
  - `MWRITE` `LED_ADDR` `16'hABCD` → `led_out == 8'hCD` after 1 edge.
  - Then `MREAD` `LED_ADDR` → `io_rd_data == 16'h00CD`, `io_rd_drive == 1` for one cycle.
  - Then `MWRITE` to 9'h0FF → `led_out` unchanged.
- Decode: `MREAD` 9'h040 (RAM) and `MREAD` 9'h141 → `io_rd_drive == 0`, `io_rd_data == 0`. Command 2'b11 at `LED_ADDR` → no write.
- Debounce, clean change: `sw_in` 8'h00→8'h5A held → `sw_stable == 8'h5A` at edge 7 with a single `sw_event` pulse. `MREAD` `SW_ADDR` afterwards → 16'h005A.
- Debounce, bounce: toggle `sw_in[0]` every 2 cycles for 20 cycles, then hold at 0 → `sw_stable[0]` never changes, no `sw_event`.
- Reset mid-debounce: assert `reset_n` low 2 edges into a count → `sw_stable` stays 0. After release, the full 3+`DEB_CYCLES` latency applies again.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared CPU memory-bus definitions: command encoding, bus widths and the
// default I/O addresses. Used by the CPU and by the I/O controller.
package mem_bus_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LED_W  = 8;
  localparam int SW_W   = 8;

  // Bus commands; 2'b11 has no name and is decoded as "no command".
  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  localparam logic [ADDR_W-1:0] LED_ADDR_DEF = 9'h100;
  localparam logic [ADDR_W-1:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/sw_debounce.sv
// Switch input conditioning: 2-flop synchronizer, one delayed copy for
// bounce detection, and a shared counter that accepts a new switch value
// only after DEB_CYCLES consecutive stable samples that differ from the
// current debounced value.
module sw_debounce #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_event
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q, s2_dly_q;
  logic [WIDTH-1:0] stable_q;
  logic             event_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous switches into the clock domain and keep one
  // extra sample so a changing input can be told apart from a held one.
  // NOTE: async active-low reset sits in the sensitivity list; state uses
  // non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s2_dly_q <= '0;
    end else begin
      s1_q     <= sw_in;
      s2_q     <= s1_q;
      s2_dly_q <= s2_q;
    end
  end

  // Count consecutive held samples that differ from the accepted value;
  // any bounce, or a return to the accepted value, restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= '0;
      event_q  <= 1'b0;
    end else if ((s2_q != stable_q) && (s2_q == s2_dly_q)) begin
      event_q <= 1'b0;
      if (cnt_q == CNT_LAST) begin
        stable_q <= s2_q;
        cnt_q    <= '0;
        event_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q   <= '0;
      event_q <= 1'b0;
    end
  end

  assign sw_stable = stable_q;
  assign sw_event  = event_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller sitting beside the RAM on the CPU bus.
// Decodes an LED register (read/write) and a debounced switch port
// (read-only). Read data is registered to match the RAM's one-cycle read
// latency; io_rd_drive tells the top-level mux to select this block.
module mmio_io_ctrl
  import mem_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LED_ADDR   = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR    = SW_ADDR_DEF,
  parameter int                DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic [DATA_W-1:0] io_rd_data,
  output logic              io_rd_drive,
  output logic [SW_W-1:0]   sw_stable,
  output logic              sw_event
);

  logic [LED_W-1:0]  led_q, led_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_drive_q, rd_drive_d;
  logic [SW_W-1:0]   sw_stable_w;

  // Only the low byte of a store reaches the LEDs.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^write_data[DATA_W-1:LED_W];

  sw_debounce #(
    .WIDTH      (SW_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_in     (sw_in),
    .sw_stable (sw_stable_w),
    .sw_event  (sw_event)
  );

  // Address decode: next LED value and next read response.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    led_d      = led_q;
    rd_data_d  = '0;
    rd_drive_d = 1'b0;
    if (mem_cmd == MWRITE && mem_addr == LED_ADDR) begin
      led_d = write_data[LED_W-1:0];
    end
    if (mem_cmd == MREAD) begin
      if (mem_addr == LED_ADDR) begin
        rd_data_d  = {{(DATA_W-LED_W){1'b0}}, led_q};
        rd_drive_d = 1'b1;
      end else if (mem_addr == SW_ADDR) begin
        rd_data_d  = {{(DATA_W-SW_W){1'b0}}, sw_stable_w};
        rd_drive_d = 1'b1;
      end
    end
  end

  // LED register and the one-cycle registered read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= '0;
      rd_data_q  <= '0;
      rd_drive_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      rd_data_q  <= rd_data_d;
      rd_drive_q <= rd_drive_d;
    end
  end

  assign led_out     = led_q;
  assign io_rd_data  = rd_data_q;
  assign io_rd_drive = rd_drive_q;
  assign sw_stable   = sw_stable_w;

endmodule
